axi_s_arb: RTL and testbench
============================

# axi_s_arb

Packet-level round-robin arbiter that shares one AXI-Stream link (the slave-side input of `axi_s_s`) between `NUM_SRC` AXI-Stream masters such as `axi_s_m`. A grant is held from the first beat of a packet until the beat carrying `tlast` is accepted, so packets are never interleaved. The arbiter sits between the masters and the single downstream slave inside a multi-source top.

## Interface
- `NUM_SRC`, 4: number of requesting stream sources, range 2..8.
- `DATA_W`, 8: tdata width in bits.
- `clk` in 1: single clock, all logic on rising edge.
- `areset` in 1: asynchronous, active-high reset.
- `s_tvalid` in NUM_SRC: per-source valid.
- `s_tdata` in NUM_SRC*DATA_W: source i occupies bits [i*DATA_W +: DATA_W].
- `s_tlast` in NUM_SRC: per-source last.
- `s_tready` out NUM_SRC: per-source ready.
- `m_tvalid` out 1: valid to the downstream slave.
- `m_tdata` out DATA_W: data to the downstream slave.
- `m_tlast` out 1: last to the downstream slave.
- `m_tready` in 1: ready from the downstream slave.
- `grant` out NUM_SRC: one-hot registered grant, all-zero when idle.
- `busy` out 1: high while a packet is locked.

## Operation
- FSM states: IDLE, LOCK. Reset state is IDLE.
- IDLE: if any `s_tvalid` bit is high, pick a winner, register `grant` = one-hot(winner), go to LOCK. If none, stay in IDLE.
- Winner selection: scan from index `rr_ptr` upward with wrap (`rr_ptr`, `rr_ptr`+1, ..., NUM_SRC-1, 0, ...). The first index with `s_tvalid` high wins.
- LOCK datapath is combinational from the granted source g:
  - `m_tvalid` = `s_tvalid[g]`, `m_tdata` = data of g, `m_tlast` = `s_tlast[g]`.
  - `s_tready[g]` = `m_tready`. All other `s_tready` bits are 0.
- LOCK exit: on `m_tvalid && m_tready && m_tlast`, go to IDLE, clear `grant`, and set `rr_ptr` = (g+1) mod NUM_SRC.
- A granted source that drops `s_tvalid` mid-packet keeps its grant. The arbiter waits indefinitely; no timeout.
- In IDLE, `m_tvalid` = 0, `m_tlast` = 0, `m_tdata` = 0, and all `s_tready` = 0.
- `busy` = (state == LOCK).

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `grant` 0, `busy` 0, `m_tvalid` 0, `m_tdata` 0, `m_tlast` 0, `s_tready` all 0.
- Arbitration latency: a source raising `s_tvalid` in cycle N while the arbiter is IDLE gets its grant registered at the edge ending cycle N. Its first beat can transfer in cycle N+1.
- Inter-packet bubble: exactly one IDLE cycle after each accepted `tlast` beat, even when other requests are pending. Maximum link throughput is L/(L+1) for L-beat packets.
- Single-beat packet (`tlast` on the first beat): LOCK lasts one cycle if `m_tready` is high.
- Simultaneous requests from all sources: grant order is `rr_ptr`, `rr_ptr`+1, ... with wrap.
- Request arriving in the same cycle as the `tlast` acceptance is not seen until the following IDLE cycle.
- `areset` asserted mid-packet: return to reset values immediately (asynchronous). The partial packet is truncated downstream; no recovery beat is generated.
- `s_tdata` and `s_tlast` of non-granted sources are ignored.

## Configuration
- `AXIS_ARB_STATS_EN` defined:
  - Adds output port `pkt_cnt` (16 bits). It increments by 1 on every accepted `tlast` beat and wraps 0xFFFF -> 0x0000.
  - Adds output port `beat_cnt` (16 bits). It increments on every accepted beat and wraps likewise.
  - Both counters reset to 0 on `areset`.
- `AXIS_ARB_STATS_EN` undefined: neither port nor the counters exist. Arbitration behaviour is identical in both builds.

## Structure
- Package `axi_s_arb_pkg`:
  - state enum {IDLE, LOCK};
  - `STAT_W` = 16;
  - function `ptr_inc` (modulo NUM_SRC increment).
- Sub-module `axi_s_rr_pick`: purely combinational rotating-priority picker. Inputs: request vector and `rr_ptr`. Outputs: one-hot winner and a valid flag. The top module holds the FSM, grant and pointer registers, and the mux.

## Test plan
- Single source: src1 sends a 3-beat packet 0xA1, 0xA2, 0xA3 (last), `m_tready`=1 -> grant=0010 one cycle after the request; `m_tdata` shows A1, A2, A3 on consecutive cycles; `m_tlast` on A3; grant=0000 on the next cycle; `rr_ptr`=2.
- All 4 sources each continuously offering 2-beat packets from reset -> grant order 0, 1, 2, 3, 0 with exactly one idle cycle between packets; no beat interleaving.
- Backpressure: src0 locked, `m_tready` held low for 5 cycles mid-packet -> `s_tready[0]`=0 and `m_tdata` stable for those cycles; no beat lost or duplicated after `m_tready` returns high.
- Source stall: granted src2 drops `s_tvalid` for 3 cycles mid-packet while src3 is requesting -> grant stays on src2, `m_tvalid`=0 during the gap; src3 is served only after src2's `tlast`.
- Reset mid-packet: assert `areset` during beat 2 of a 4-beat src1 packet -> `m_tvalid`, `grant`, `busy` go to 0 immediately; after release, src0 is granted first if it is requesting (`rr_ptr`=0).
- With `AXIS_ARB_STATS_EN`: 5 packets totalling 12 beats -> `pkt_cnt`=5, `beat_cnt`=12. Preload counters to 0xFFFF via a forced run -> next packet wraps `pkt_cnt` to 0.

Source files
------------

// File: rtl/axi_s_arb_pkg.sv
// Shared types and helpers for the packet-level AXI-Stream round-robin arbiter.
// PTR_W is wide enough to index up to 8 sources.
package axi_s_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int STAT_W = 16;
    localparam int PTR_W  = 3;

    // Advance a source index by one, wrapping at num_src.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr,
                                                 input int num_src);
        if (int'(ptr) >= num_src - 1) begin
            return '0;
        end else begin
            return ptr + 1'b1;
        end
    endfunction

endpackage

// File: rtl/axi_s_arb_if.sv
// Stream bundle around the arbiter: NUM_SRC source-side channels and one sink-side channel.
// master = the environment (sources and downstream sink), slave = the arbiter.
interface axi_s_arb_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_SRC-1:0]        s_tvalid;
    logic [NUM_SRC*DATA_W-1:0] s_tdata;
    logic [NUM_SRC-1:0]        s_tlast;
    logic [NUM_SRC-1:0]        s_tready;
    logic                      m_tvalid;
    logic [DATA_W-1:0]         m_tdata;
    logic                      m_tlast;
    logic                      m_tready;

    modport master (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/axi_s_rr_pick.sv
// Combinational rotating-priority picker: lowest requesting index at or above rr_ptr wins,
// otherwise the lowest requesting index overall (wrap-around).
module axi_s_rr_pick
    import axi_s_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_SRC-1:0] winner,
    output logic               valid
);

    logic [NUM_SRC-1:0] hi_oh;
    logic [NUM_SRC-1:0] lo_oh;
    logic               hi_any;

    // NOTE: every output of an always_comb gets a default before any branch, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        hi_oh  = '0;
        lo_oh  = '0;
        hi_any = 1'b0;
        // Descending scan: the last hit written is the lowest index.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_oh    = '0;
                lo_oh[i] = 1'b1;
                if (i >= int'(rr_ptr)) begin
                    hi_oh    = '0;
                    hi_oh[i] = 1'b1;
                    hi_any   = 1'b1;
                end
            end
        end
        winner = hi_any ? hi_oh : lo_oh;
        valid  = |req;
    end

endmodule

// File: rtl/axi_s_arb.sv
// Packet-level round-robin arbiter: holds a grant from first beat to accepted tlast.
// Optional statistics counters (pkt_cnt, beat_cnt) are built when AXIS_ARB_STATS_EN is defined.
module axi_s_arb
    import axi_s_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               areset,
    axi_s_arb_if.slave         bus,
    output logic [NUM_SRC-1:0] grant,
    output logic               busy
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]  pkt_cnt,
    output logic [STAT_W-1:0]  beat_cnt
`endif
);

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] grant_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   g_idx;
    logic [NUM_SRC-1:0] pick_oh;
    logic               pick_vld;
    logic               last_acc;

    logic               m_tvalid_c;
    logic [DATA_W-1:0]  m_tdata_c;
    logic               m_tlast_c;
    logic [NUM_SRC-1:0] s_tready_c;

    axi_s_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req    (bus.s_tvalid),
        .rr_ptr (rr_ptr_q),
        .winner (pick_oh),
        .valid  (pick_vld)
    );

    // NOTE: state is written with non-blocking assignments so every register samples
    // its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q  <= IDLE;
            grant    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Datapath follows the registered grant; grant is all-zero outside LOCK.
    always_comb begin
        m_tvalid_c = 1'b0;
        m_tdata_c  = '0;
        m_tlast_c  = 1'b0;
        s_tready_c = '0;
        g_idx      = '0;
        if (state_q == LOCK) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant[i]) begin
                    m_tvalid_c    = bus.s_tvalid[i];
                    m_tdata_c     = bus.s_tdata[i*DATA_W +: DATA_W];
                    m_tlast_c     = bus.s_tlast[i];
                    s_tready_c[i] = bus.m_tready;
                    g_idx         = PTR_W'(i);
                end
            end
        end
    end

    assign last_acc     = m_tvalid_c && bus.m_tready && m_tlast_c;
    assign bus.m_tvalid = m_tvalid_c;
    assign bus.m_tdata  = m_tdata_c;
    assign bus.m_tlast  = m_tlast_c;
    assign bus.s_tready = s_tready_c;
    assign busy         = (state_q == LOCK);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_oh;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                // Leaving on tlast forces the one-cycle bubble before the next grant.
                if (last_acc) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = ptr_inc(g_idx, NUM_SRC);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

`ifdef AXIS_ARB_STATS_EN
    logic beat_acc;

    assign beat_acc = m_tvalid_c && bus.m_tready;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            pkt_cnt  <= '0;
            beat_cnt <= '0;
        end else if (beat_acc) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (m_tlast_c) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_s_arb.sv
// Self-checking bench for axi_s_arb: a vector table for basic arbitration plus directed
// sequences for round-robin order, backpressure, stalls, reset and (optionally) statistics.
module tb_axi_s_arb;
    import axi_s_arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         areset;
    logic [N-1:0] grant;
    logic         busy;

    axi_s_arb_if #(.NUM_SRC(N), .DATA_W(W)) bus ();

`ifdef AXIS_ARB_STATS_EN
    logic [STAT_W-1:0] pkt_cnt;
    logic [STAT_W-1:0] beat_cnt;

    axi_s_arb #(.NUM_SRC(N), .DATA_W(W)) dut (
        .clk      (clk),
        .areset   (areset),
        .bus      (bus),
        .grant    (grant),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt),
        .beat_cnt (beat_cnt)
    );
`else
    axi_s_arb #(.NUM_SRC(N), .DATA_W(W)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus),
        .grant  (grant),
        .busy   (busy)
    );
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0]   vld;
        logic [N*W-1:0] data;
        logic [N-1:0]   last;
        logic           rdy;
        logic [N-1:0]   e_grant;
        logic           e_busy;
        logic           e_mvalid;
        logic [W-1:0]   e_mdata;
        logic           e_mlast;
        logic [N-1:0]   e_sready;
    } vec_t;

    vec_t vecs[12];

    // Source model: each source offers `left` packets of `len` beats, data = base + beat.
    int           len[N];
    int           beat[N];
    int           left[N];
    logic [W-1:0] base[N];
    logic         stall[N];

    logic [N-1:0] o_vld, o_rdy, o_grant;
    logic         o_busy, o_mvalid, o_mlast;
    logic [W-1:0] o_mdata;
    logic [W-1:0] acc_q[$];
    logic [N-1:0] acc_g[$];

    task automatic set_src(input int i, input int l, input int p, input logic [W-1:0] b);
        len[i]  = l;
        left[i] = p;
        beat[i] = 0;
        base[i] = b;
    endtask

    task automatic drive_model();
        for (int i = 0; i < N; i++) begin
            bus.s_tvalid[i]          = (left[i] > 0) && !stall[i];
            bus.s_tdata[i*W +: W]    = base[i] + W'(beat[i]);
            bus.s_tlast[i]           = (beat[i] == len[i] - 1);
        end
    endtask

    task automatic cycle();
        drive_model();
        @(negedge clk);
        o_vld    = bus.s_tvalid;
        o_rdy    = bus.s_tready;
        o_grant  = grant;
        o_busy   = busy;
        o_mvalid = bus.m_tvalid;
        o_mdata  = bus.m_tdata;
        o_mlast  = bus.m_tlast;
        if (bus.m_tvalid && bus.m_tready) begin
            acc_q.push_back(bus.m_tdata);
            acc_g.push_back(grant);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (o_vld[i] && o_rdy[i]) begin
                beat[i]++;
                if (beat[i] == len[i]) begin
                    beat[i] = 0;
                    left[i]--;
                end
            end
        end
    endtask

    task automatic do_reset();
        areset       = 1'b1;
        bus.s_tvalid = '0;
        bus.s_tdata  = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_src(i, 1, 0, '0);
            stall[i] = 1'b0;
        end
        acc_q.delete();
        acc_g.delete();
        @(posedge clk);
        #1;
        areset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] exp_d[6];
        logic [N-1:0] exp_g[6];
        int           phase, src;
        bit           done;

        vecs[0]  = '{4'b0010, 32'h5555A155, 4'b1101, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000};
        vecs[1]  = '{4'b0010, 32'h5555A155, 4'b1101, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA1, 1'b0, 4'b0010};
        vecs[2]  = '{4'b0010, 32'h5555A255, 4'b1101, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA2, 1'b0, 4'b0010};
        vecs[3]  = '{4'b0010, 32'h5555A355, 4'b1011, 1'b1, 4'b0010, 1'b1, 1'b1, 8'hA3, 1'b1, 4'b0010};
        vecs[4]  = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000};
        vecs[5]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000};
        vecs[6]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 8'h33, 1'b1, 4'b0100};
        vecs[7]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000};
        vecs[8]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 8'h44, 1'b1, 4'b1000};
        vecs[9]  = '{4'b1111, 32'h44332211, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000};
        vecs[10] = '{4'b1111, 32'h44332211, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 8'h11, 1'b1, 4'b0001};
        vecs[11] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0, 4'b0000};

        // Reset state while reset is held.
        areset       = 1'b1;
        bus.s_tvalid = 4'b1111;
        bus.s_tdata  = 32'hFFFFFFFF;
        bus.s_tlast  = 4'b1111;
        bus.m_tready = 1'b1;
        #12;
        check("reset grant",    32'(grant), 32'h0);
        check("reset busy",     32'(busy), 32'h0);
        check("reset m_tvalid", 32'(bus.m_tvalid), 32'h0);
        check("reset m_tdata",  32'(bus.m_tdata), 32'h0);
        check("reset m_tlast",  32'(bus.m_tlast), 32'h0);
        check("reset s_tready", 32'(bus.s_tready), 32'h0);

        // Vector table: single 3-beat packet from src1, then all sources with single beats.
        do_reset();
        for (int v = 0; v < 12; v++) begin
            bus.s_tvalid = vecs[v].vld;
            bus.s_tdata  = vecs[v].data;
            bus.s_tlast  = vecs[v].last;
            bus.m_tready = vecs[v].rdy;
            @(negedge clk);
            check($sformatf("vec%0d grant", v),    32'(grant),         32'(vecs[v].e_grant));
            check($sformatf("vec%0d busy", v),     32'(busy),          32'(vecs[v].e_busy));
            check($sformatf("vec%0d m_tvalid", v), 32'(bus.m_tvalid),  32'(vecs[v].e_mvalid));
            check($sformatf("vec%0d m_tdata", v),  32'(bus.m_tdata),   32'(vecs[v].e_mdata));
            check($sformatf("vec%0d m_tlast", v),  32'(bus.m_tlast),   32'(vecs[v].e_mlast));
            check($sformatf("vec%0d s_tready", v), 32'(bus.s_tready),  32'(vecs[v].e_sready));
            @(posedge clk);
            #1;
        end

        // All sources continuously offering 2-beat packets: order 0,1,2,3,0 with one bubble.
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, 2, 2, W'(8'h10 * (i + 1)));
        for (int k = 0; k < 15; k++) begin
            cycle();
            phase = k % 3;
            src   = (k / 3) % N;
            check($sformatf("rr%0d grant", k), 32'(o_grant), (phase == 0) ? 32'h0 : (32'h1 << src));
            check($sformatf("rr%0d busy", k), 32'(o_busy), (phase == 0) ? 32'h0 : 32'h1);
            check($sformatf("rr%0d m_tvalid", k), 32'(o_mvalid), (phase == 0) ? 32'h0 : 32'h1);
            check($sformatf("rr%0d m_tdata", k), 32'(o_mdata),
                  (phase == 0) ? 32'h0 : 32'(8'h10 * (src + 1) + phase - 1));
            check($sformatf("rr%0d m_tlast", k), 32'(o_mlast), (phase == 2) ? 32'h1 : 32'h0);
        end

        // Backpressure: m_tready low for 5 cycles during beat 1 of a src0 packet.
        do_reset();
        set_src(0, 4, 1, 8'hB0);
        cycle();
        cycle();
        check("bp first beat", 32'(o_mdata), 32'hB0);
        bus.m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check($sformatf("bp%0d s_tready", k), 32'(o_rdy), 32'h0);
            check($sformatf("bp%0d m_tvalid", k), 32'(o_mvalid), 32'h1);
            check($sformatf("bp%0d m_tdata", k), 32'(o_mdata), 32'hB1);
        end
        bus.m_tready = 1'b1;
        repeat (4) cycle();
        check("bp beat count", 32'(acc_q.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < acc_q.size()) check($sformatf("bp beat%0d", j), 32'(acc_q[j]), 32'(8'hB0 + j));
        end

        // Source stall: granted src2 drops valid for 3 cycles while src3 waits.
        do_reset();
        set_src(2, 4, 1, 8'hC0);
        set_src(3, 2, 1, 8'hD0);
        cycle();
        cycle();
        stall[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check($sformatf("stall%0d grant", k), 32'(o_grant), 32'b0100);
            check($sformatf("stall%0d m_tvalid", k), 32'(o_mvalid), 32'h0);
            check($sformatf("stall%0d s_tready", k), 32'(o_rdy), 32'b0100);
        end
        stall[2] = 1'b0;
        repeat (3) cycle();
        cycle();
        check("stall bubble grant", 32'(o_grant), 32'h0);
        check("stall bubble busy", 32'(o_busy), 32'h0);
        cycle();
        check("stall src3 grant", 32'(o_grant), 32'b1000);
        check("stall src3 data", 32'(o_mdata), 32'hD0);
        cycle();
        exp_d = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1};
        exp_g = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
        check("stall beat count", 32'(acc_q.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            if (j < acc_q.size()) begin
                check($sformatf("stall beat%0d data", j), 32'(acc_q[j]), 32'(exp_d[j]));
                check($sformatf("stall beat%0d src", j), 32'(acc_g[j]), 32'(exp_g[j]));
            end
        end

        // Reset during beat 2 of a 4-beat src1 packet, after rr_ptr has moved to 2.
        do_reset();
        set_src(1, 1, 1, 8'h70);
        repeat (3) cycle();
        set_src(1, 4, 1, 8'hE0);
        cycle();
        cycle();
        drive_model();
        @(negedge clk);
        check("rst mid m_tdata", 32'(bus.m_tdata), 32'hE1);
        check("rst mid busy", 32'(busy), 32'h1);
        #1;
        areset = 1'b1;
        #1;
        check("rst async grant", 32'(grant), 32'h0);
        check("rst async busy", 32'(busy), 32'h0);
        check("rst async m_tvalid", 32'(bus.m_tvalid), 32'h0);
        check("rst async s_tready", 32'(bus.s_tready), 32'h0);
        @(posedge clk);
        #1;
        areset = 1'b0;
        acc_q.delete();
        acc_g.delete();
        set_src(0, 1, 1, 8'h01);
        set_src(1, 1, 1, 8'h02);
        set_src(2, 1, 1, 8'h03);
        cycle();
        check("post rst idle grant", 32'(o_grant), 32'h0);
        cycle();
        check("post rst grant", 32'(o_grant), 32'b0001);
        check("post rst data", 32'(o_mdata), 32'h01);
        check("post rst first beat", 32'(acc_q.size()), 32'd1);

`ifdef AXIS_ARB_STATS_EN
        // Statistics: 5 packets, 12 beats, then wrap from 0xFFFF.
        do_reset();
        set_src(0, 3, 2, 8'h20);
        set_src(1, 1, 1, 8'h30);
        set_src(2, 2, 1, 8'h40);
        set_src(3, 3, 1, 8'h50);
        done = 1'b0;
        for (int k = 0; k < 100 && !done; k++) begin
            cycle();
            done = (left[0] == 0) && (left[1] == 0) && (left[2] == 0) && (left[3] == 0);
        end
        check("stats run completed", 32'(done), 32'h1);
        cycle();
        check("stats pkt_cnt", 32'(pkt_cnt), 32'd5);
        check("stats beat_cnt", 32'(beat_cnt), 32'd12);
        @(negedge clk);
        force dut.pkt_cnt = 16'hFFFF;
        force dut.beat_cnt = 16'hFFFF;
        #1;
        release dut.pkt_cnt;
        release dut.beat_cnt;
        @(posedge clk);
        #1;
        check("stats preload pkt_cnt", 32'(pkt_cnt), 32'hFFFF);
        set_src(0, 1, 1, 8'h60);
        repeat (3) cycle();
        check("stats wrap pkt_cnt", 32'(pkt_cnt), 32'h0);
        check("stats wrap beat_cnt", 32'(beat_cnt), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
